// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
// master = pipeline/decoder side, slave = hazard_ctrl
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_ra1;
  logic [REG_W-1:0] id_ra2;
  logic             id_uses_ra2;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             mem_branch_taken;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [1:0]       state;

  modport master (
    output id_ra1, id_ra2, id_uses_ra2, ex_memread, ex_rd,
           mem_branch_taken, mem_access, dmem_ready,
    input  pc_write, ifid_write, idex_bubble, flush, pipe_freeze,
           mem_timeout, state
  );

  modport slave (
    input  id_ra1, id_ra2, id_uses_ra2, ex_memread, ex_rd,
           mem_branch_taken, mem_access, dmem_ready,
    output pc_write, ifid_write, idex_bubble, flush, pipe_freeze,
           mem_timeout, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - LEGv8 hazard/freeze controller with hung-memory trap
// Optional performance counters enabled by macro HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_freeze_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_WAIT = 2'b01,
    S_TRAP = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
  localparam logic [REG_W-1:0] XZR      = {REG_W{1'b1}};

  state_t           state_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  logic load_use;
  logic mem_stall;
  logic pc_w, ifid_w, bubble, flush_w, freeze;

  always_comb begin
    load_use  = hif.ex_memread && (hif.ex_rd != XZR) &&
                ((hif.ex_rd == hif.id_ra1) ||
                 (hif.id_uses_ra2 && (hif.ex_rd == hif.id_ra2)));
    mem_stall = hif.mem_access && !hif.dmem_ready;

    // RUN rules, priority freeze > flush > load-use stall
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    bubble  = 1'b0;
    flush_w = 1'b0;
    freeze  = 1'b0;
    if (mem_stall) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      freeze = 1'b1;
    end else if (hif.mem_branch_taken) begin
      flush_w = 1'b1;
    end else if (load_use) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      bubble = 1'b1;
    end

    // WAIT with ready falls through to the RUN rules; TRAP and 11 freeze
    if ((state_q == S_WAIT && !hif.dmem_ready) ||
        (state_q != S_RUN && state_q != S_WAIT)) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      bubble  = 1'b0;
      flush_w = 1'b0;
      freeze  = 1'b1;
    end
  end

  assign hif.pc_write    = pc_w;
  assign hif.ifid_write  = ifid_w;
  assign hif.idex_bubble = bubble;
  assign hif.flush       = flush_w;
  assign hif.pipe_freeze = freeze;
  assign hif.mem_timeout = timeout_q | state_q[1];
  assign hif.state       = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_stall) begin
            state_q  <= S_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (hif.dmem_ready) begin
            state_q  <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt < WAIT_LIM) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            state_q   <= S_TRAP;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_TRAP;
          timeout_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else if (!state_q[1]) begin
      perf_stall_cnt  <= perf_stall_cnt  + {31'd0, bubble};
      perf_flush_cnt  <= perf_flush_cnt  + {31'd0, flush_w};
      perf_freeze_cnt <= perf_freeze_cnt + {31'd0, freeze};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (WAIT_MAX=4)
module tb_hazard_ctrl;
  localparam int REG_W = 5;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  hazard_ctrl_if #(.REG_W(REG_W)) hif ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_freeze_cnt (perf_freeze_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  // {pc_write, ifid_write, idex_bubble, flush, pipe_freeze, mem_timeout, state[1:0]}
  localparam logic [7:0] E_NORM   = 8'b1100_0000;
  localparam logic [7:0] E_BUB    = 8'b0010_0000;
  localparam logic [7:0] E_FLUSH  = 8'b1101_0000;
  localparam logic [7:0] E_FRZ_R  = 8'b0000_1000;
  localparam logic [7:0] E_FRZ_W  = 8'b0000_1001;
  localparam logic [7:0] E_TRAP   = 8'b0000_1110;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  function automatic logic [7:0] observed();
    return {hif.pc_write, hif.ifid_write, hif.idex_bubble, hif.flush,
            hif.pipe_freeze, hif.mem_timeout, hif.state};
  endfunction

  task automatic drive(input logic ma, input logic dr, input logic br,
                       input logic mr, input int rd, input int ra1,
                       input int ra2, input logic uses);
    hif.mem_access       = ma;
    hif.dmem_ready       = dr;
    hif.mem_branch_taken = br;
    hif.ex_memread       = mr;
    hif.ex_rd            = REG_W'(rd);
    hif.id_ra1           = REG_W'(ra1);
    hif.id_ra2           = REG_W'(ra2);
    hif.id_uses_ra2      = uses;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [7:0] e;
    logic [7:0] o;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    total_cnt++;
    assert (o === e) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %b expected %b", t, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] e);
    expect_out(tag, e);
    #1;
    check_out();
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
    total_cnt++;
    assert (o === e) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    drive(0, 0, 0, 1, 3, 3, 0, 0);
    expect_out("reset_loaduse", E_BUB);
    #1; check_out();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_memstall", E_FRZ_R);
    #1; check_out();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    step("idle", E_NORM);
    drive(0, 0, 0, 1, 3, 3, 0, 0);
    step("loaduse_ra1", E_BUB);
    drive(0, 0, 0, 0, 3, 3, 0, 0);
    step("loaduse_clear", E_NORM);
    drive(0, 0, 0, 1, 31, 31, 31, 1);
    step("xzr_no_hazard", E_NORM);
    drive(0, 0, 0, 1, 5, 1, 5, 1);
    step("loaduse_ra2", E_BUB);
    drive(0, 0, 0, 1, 5, 1, 5, 0);
    step("ra2_unused", E_NORM);
    drive(0, 0, 1, 1, 3, 3, 0, 0);
    step("branch_over_loaduse", E_FLUSH);

    // three frozen cycles, then ready with a branch in the same cycle
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("wait_run_freeze", E_FRZ_R);
    step("wait_frz1", E_FRZ_W);
    step("wait_frz2", E_FRZ_W);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    step("wait_ready_branch", 8'b1101_0001);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("wait_back_run", E_NORM);

    // ready with a load-use hazard in the same cycle
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("wait2_run_freeze", E_FRZ_R);
    drive(1, 1, 0, 1, 7, 7, 0, 0);
    step("wait2_ready_loaduse", 8'b0010_0001);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("wait2_back_run", E_NORM);

    // timeout: WAIT_MAX+1 = 5 frozen cycles then TRAP
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("to_run_freeze", E_FRZ_R);
    for (int i = 0; i < 4; i++) step($sformatf("to_wait%0d", i), E_FRZ_W);
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), 1'($urandom));
      step($sformatf("trap_hold%0d", i), E_TRAP);
    end

    // asynchronous reset in the middle of a TRAP cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    expect_out("async_reset_trap", E_NORM);
    #1; check_out();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    step("after_reset", E_NORM);

    // 2 bubbles, 1 flush, 3 freeze cycles since reset
    drive(0, 0, 0, 1, 9, 9, 0, 0);
    step("perf_bub1", E_BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("perf_gap", E_NORM);
    drive(0, 0, 0, 1, 9, 0, 9, 1);
    step("perf_bub2", E_BUB);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    step("perf_flush", E_FLUSH);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("perf_frz1", E_FRZ_R);
    step("perf_frz2", E_FRZ_W);
    step("perf_frz3", E_FRZ_W);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    step("perf_ready", 8'b1100_0001);
`ifdef HAZARD_PERF_EN
    check_cnt("perf_stall", perf_stall_cnt, 32'd2);
    check_cnt("perf_flush", perf_flush_cnt, 32'd1);
    check_cnt("perf_freeze", perf_freeze_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage LEGv8 core. It sits beside the main decoder and pipeline registers, and generates PC/IF-ID write enables, ID/EX bubble insertion, branch flushes and whole-pipeline freeze.
- Freeze covers multi-cycle data-memory accesses.
- A bounded wait counter traps a hung memory.

Parameters:
- REG_W, 5, register-address width.
- WAIT_MAX, 15, maximum consecutive wait cycles before trap (1..255).
- CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- id_ra1  in  REG_W  ID-stage first read address (Rn).
- id_ra2  in  REG_W  ID-stage second read address (Rm or Rt, after Reg2Loc mux).
- id_uses_ra2  in  1  ID instruction actually reads id_ra2.
- ex_memread  in  1  ID/EX MemRead (LDUR in EX).
- ex_rd  in  REG_W  ID/EX destination register.
- mem_branch_taken  in  1  Branch & Zero in MEM stage.
- mem_access  in  1  MemRead|MemWrite in MEM stage.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_bubble  out  1  force ID/EX control bits to 0.
- flush  out  1  clear IF/ID, ID/EX, EX/MEM valid/control.
- pipe_freeze  out  1  hold every pipeline register, PC and register-file write.
- mem_timeout  out  1  sticky trap flag.
- state  out  2  RUN=00, WAIT=01, TRAP=10.

Behaviour:
- Reset (async, reset=0): state=RUN, wait_cnt=0, mem_timeout=0.
- Output values while reset is asserted are the RUN-state values for the current inputs.
- Derived terms (combinational):
  - load_use = ex_memread & ex_rd!=31 & (ex_rd==id_ra1 | (id_uses_ra2 & ex_rd==id_ra2)). XZR (31) never hazards.
  - mem_stall = mem_access & ~dmem_ready.
- Outputs are combinational from state and inputs. Priority: freeze > flush > load-use stall.
- RUN, mem_stall=1:
  - pipe_freeze=1, pc_write=0, ifid_write=0, flush=0, idex_bubble=0.
  - Next state=WAIT, wait_cnt<=1.
- RUN, mem_stall=0, mem_branch_taken=1:
  - flush=1, pc_write=1, ifid_write=1, idex_bubble=0.
  - load_use is ignored because the instruction causing it is flushed.
- RUN, no stall, no branch, load_use=1:
  - pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle.
  - Next cycle load_use deasserts naturally, giving a 1-cycle bubble.
- RUN, otherwise: pc_write=1, ifid_write=1, all other controls 0.
- WAIT:
  - pipe_freeze = ~dmem_ready. While frozen: pc_write=0, ifid_write=0, flush=0, idex_bubble=0.
  - dmem_ready=1: freeze drops in the same cycle and RUN rules are applied to the current inputs, so a branch or load-use in that cycle is handled. Next state=RUN, wait_cnt<=0.
  - dmem_ready=0 and wait_cnt<WAIT_MAX: wait_cnt increments.
  - dmem_ready=0 and wait_cnt==WAIT_MAX: next state=TRAP, mem_timeout<=1.
  - Total frozen cycles before trap = WAIT_MAX+1.
- TRAP:
  - pipe_freeze=1, pc_write=0, ifid_write=0, flush=0, idex_bubble=0, mem_timeout=1.
  - All inputs are ignored. Exit only via reset.
- Counter never wraps; it saturates at WAIT_MAX.
- Reset asserted mid-WAIT or mid-TRAP: immediate return to RUN, counter and flag cleared.
- Unused state encoding 11: treated as TRAP.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds outputs:
  - perf_stall_cnt (32): counts load-use bubble cycles.
  - perf_flush_cnt (32): counts flush cycles.
  - perf_freeze_cnt (32): counts pipe_freeze cycles.
- All three counters are cleared by reset, wrap modulo 2^32, and do not count while state=TRAP.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_ra1=3 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1; with ex_rd=31 → no stall.
- Branch with hazard: mem_branch_taken=1 and load_use=1 same cycle → flush=1, pc_write=1, idex_bubble=0.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 → pipe_freeze=1 for 3 cycles, state WAIT; RUN after ready, mem_timeout=0.
- Timeout: WAIT_MAX=4, dmem_ready held 0 → freeze for 5 cycles, then state=TRAP, mem_timeout=1, held for 20 further cycles regardless of inputs.
- Reset in TRAP: drive reset=0 asynchronously mid-cycle → state=RUN, mem_timeout=0 before next clock edge.
- HAZARD_PERF_EN: 2 bubbles, 1 flush, 3 freeze cycles → perf counters read 2/1/3.
